// File: rtl/bus_sync_pkg.sv
// rtl/bus_sync_pkg.sv - shared types and defaults for the bus synchroniser sender
package bus_sync_pkg;

  typedef enum logic [1:0] {IDLE, SETUP, HOLD, GAP} sender_state_t;

  localparam int DEF_BUS_WIDTH   = 8;
  localparam int DEF_FIFO_DEPTH  = 4;
  localparam int DEF_HOLD_CYCLES = 4;
  localparam int DEF_GAP_CYCLES  = 4;

  // Phase counter must be able to hold the longer of the two phase lengths.
  function automatic int cnt_width(input int hold_cycles, input int gap_cycles);
    int longest;
    longest = (hold_cycles > gap_cycles) ? hold_cycles : gap_cycles;
    return (longest < 1) ? 1 : $clog2(longest + 1);
  endfunction

endpackage

// File: rtl/bus_sync_sender_if.sv
// rtl/bus_sync_sender_if.sv - producer stream plus synchroniser-facing bus of the sender
interface bus_sync_sender_if
  import bus_sync_pkg::*;
#(
  parameter int BUS_WIDTH = DEF_BUS_WIDTH
);

  logic [BUS_WIDTH-1:0] in_data;
  logic                 in_valid;
  logic                 in_ready;
  logic [BUS_WIDTH-1:0] unsync_bus;
  logic                 bus_enable;
  logic                 busy;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready,
    input  unsync_bus,
    input  bus_enable,
    input  busy
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready,
    output unsync_bus,
    output bus_enable,
    output busy
  );

endinterface

// File: rtl/bus_sync_sender_fifo.sv
// rtl/bus_sync_sender_fifo.sv - synchronous word FIFO with wrap-bit pointers
module sender_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head_data = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/bus_sync_sender.sv
// rtl/bus_sync_sender.sv - source-domain sender: buffers words, presents each one with
// a held bus and a single bus_enable window for the destination 2-flop synchroniser
module bus_sync_sender
  import bus_sync_pkg::*;
#(
  parameter int BUS_WIDTH   = DEF_BUS_WIDTH,
  parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH,
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
  parameter int GAP_CYCLES  = DEF_GAP_CYCLES
) (
  input  logic            clk,
  input  logic            rst,
  bus_sync_sender_if.slave bus
);

  localparam int CW = cnt_width(HOLD_CYCLES, GAP_CYCLES);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX   = '1;

  sender_state_t        state;
  sender_state_t        state_next;
  logic [CW-1:0]        cnt;
  logic [CW-1:0]        cnt_next;
  logic [BUS_WIDTH-1:0] unsync_q;
  logic                 enable_q;
  logic                 pop;
  logic                 push;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [BUS_WIDTH-1:0] head_data;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] value);
    return (value == CNT_MAX) ? value : value + CW'(1);
  endfunction

  assign bus.in_ready = !rst && !fifo_full;
  assign push         = bus.in_valid && bus.in_ready;

  sender_fifo #(
    .WIDTH (BUS_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (bus.in_data),
    .pop       (pop),
    .head_data (head_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    pop        = 1'b0;
    unique case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          state_next = SETUP;
        end
      end
      SETUP: begin
        state_next = HOLD;
        cnt_next   = '0;
      end
      HOLD: begin
        if (cnt == HOLD_LAST) begin
          state_next = GAP;
          cnt_next   = '0;
        end else begin
          cnt_next = sat_inc(cnt);
        end
      end
      GAP: begin
        if (cnt == GAP_LAST) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = sat_inc(cnt);
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // bus_enable comes from a flop fed by the next state, so it never glitches
  // and rises one cycle after the word has been placed on unsync_bus.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      unsync_q <= '0;
      enable_q <= 1'b0;
    end else begin
      state    <= state_next;
      cnt      <= cnt_next;
      enable_q <= (state_next == HOLD);
      if (pop) unsync_q <= head_data;
    end
  end

  assign bus.unsync_bus = unsync_q;
  assign bus.bus_enable = enable_q;
  assign bus.busy       = (state != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_bus_sync_sender.sv
// tb/tb_bus_sync_sender.sv - bench for bus_sync_sender at default and minimal parameters
module tb_bus_sync_sender;

  logic clk = 1'b0;
  logic dclk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;
  always #7 dclk = ~dclk;

  bus_sync_sender_if #(.BUS_WIDTH(8)) bus_a ();
  bus_sync_sender_if #(.BUS_WIDTH(8)) bus_b ();

  bus_sync_sender #(
    .BUS_WIDTH (8), .FIFO_DEPTH (4), .HOLD_CYCLES (4), .GAP_CYCLES (4)
  ) dut_a (
    .clk (clk), .rst (rst), .bus (bus_a.slave)
  );

  bus_sync_sender #(
    .BUS_WIDTH (8), .FIFO_DEPTH (2), .HOLD_CYCLES (1), .GAP_CYCLES (1)
  ) dut_b (
    .clk (clk), .rst (rst), .bus (bus_b.slave)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: per word, the pop edge is max(accept edge + 1, previous pop + period);
  // everything observable follows from the pop edge by fixed offsets.
  int         mh [2];
  int         mg [2];
  int         md [2];
  logic [7:0] mbuf [2][16];
  int         mhead [2];
  int         mcount [2];
  bit         have_pop [2];
  int         last_pop [2];
  logic [7:0] cur_word [2];
  bit         ready_now [2];
  int         e = 0;
  bit         last_acc0;
  logic [7:0] dq [$];

  task automatic model_edge(input int m, input bit r, input bit v, input logic [7:0] d);
    int period;
    period = 2 + mh[m] + mg[m];
    if (r) begin
      mcount[m]   = 0;
      mhead[m]    = 0;
      have_pop[m] = 0;
      cur_word[m] = 8'h00;
      if (m == 0) dq.delete();
    end else begin
      if (mcount[m] > 0 && (!have_pop[m] || e >= last_pop[m] + period)) begin
        cur_word[m] = mbuf[m][mhead[m]];
        mhead[m]    = (mhead[m] + 1) % 16;
        mcount[m]--;
        have_pop[m] = 1;
        last_pop[m] = e;
        if (m == 0) dq.push_back(cur_word[m]);
      end
      if (v && ready_now[m]) begin
        mbuf[m][(mhead[m] + mcount[m]) % 16] = d;
        mcount[m]++;
      end
    end
  endtask

  task automatic check_outputs(input int m);
    bit         exp_en;
    bit         exp_busy;
    logic [7:0] obs_bus;
    logic       obs_en;
    logic       obs_busy;
    exp_en   = have_pop[m] && (e >= last_pop[m] + 1) && (e <= last_pop[m] + mh[m]);
    exp_busy = (mcount[m] > 0) || (have_pop[m] && (e <= last_pop[m] + mh[m] + mg[m]));
    if (m == 0) begin
      obs_bus = bus_a.unsync_bus; obs_en = bus_a.bus_enable; obs_busy = bus_a.busy;
    end else begin
      obs_bus = bus_b.unsync_bus; obs_en = bus_b.bus_enable; obs_busy = bus_b.busy;
    end
    check((m == 0) ? "a_unsync_bus" : "b_unsync_bus", 32'(obs_bus), 32'(cur_word[m]));
    check((m == 0) ? "a_bus_enable" : "b_bus_enable", 32'(obs_en), 32'(exp_en));
    check((m == 0) ? "a_busy" : "b_busy", 32'(obs_busy), 32'(exp_busy));
  endtask

  task automatic cycle(input bit r, input bit v, input logic [7:0] d);
    rst            = r;
    bus_a.in_valid = v;
    bus_a.in_data  = d;
    bus_b.in_valid = v;
    bus_b.in_data  = d;
    for (int m = 0; m < 2; m++) ready_now[m] = !r && (mcount[m] < md[m]);
    last_acc0 = v && ready_now[0];
    #1;
    check("a_in_ready", 32'(bus_a.in_ready), 32'(ready_now[0]));
    check("b_in_ready", 32'(bus_b.in_ready), 32'(ready_now[1]));
    @(posedge clk);
    e++;
    model_edge(0, r, v, d);
    model_edge(1, r, v, d);
    @(negedge clk);
    check_outputs(0);
    check_outputs(1);
  endtask

  // Destination-domain 2-flop synchroniser and edge detector on DUT A.
  logic s1 = 1'b0, s2 = 1'b0, s3 = 1'b0;
  int   words_seen = 0;

  always @(posedge dclk) begin
    s1 <= bus_a.bus_enable;
    s2 <= s1;
    s3 <= s2;
    if (s2 && !s3 && !rst) begin
      if (dq.size() == 0) begin
        check("dest_unexpected_pulse", 32'(1), 32'(0));
      end else begin
        check("dest_word", 32'(bus_a.unsync_bus), 32'(dq.pop_front()));
        words_seen++;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] burst [5];
    int         idx;
    int         guard;
    int         rst_left;
    bit         v;

    mh = '{4, 1};
    mg = '{4, 1};
    md = '{4, 2};
    for (int m = 0; m < 2; m++) begin
      mhead[m] = 0; mcount[m] = 0; have_pop[m] = 0; last_pop[m] = 0; cur_word[m] = 8'h00;
    end
    bus_a.in_valid = 1'b1; bus_a.in_data = 8'h5A;
    bus_b.in_valid = 1'b1; bus_b.in_data = 8'h5A;

    // Reset with a producer insisting on valid: nothing may be stored.
    cycle(1, 1, 8'h5A);
    cycle(1, 1, 8'h5A);
    for (int i = 0; i < 4; i++) cycle(0, 0, 8'h00);

    // Single word.
    cycle(0, 1, 8'hA5);
    for (int i = 0; i < 25; i++) cycle(0, 0, 8'h00);

    // Back-to-back burst; the producer holds each word until DUT A takes it.
    burst = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    idx = 0;
    guard = 0;
    while (idx < 5 && guard < 100) begin
      cycle(0, 1, burst[idx]);
      if (last_acc0) idx++;
      guard++;
    end
    check("burst_accepted", 32'(idx), 32'(5));
    for (int i = 0; i < 70; i++) cycle(0, 0, 8'h00);

    // Reset during the second HOLD cycle with further words queued.
    cycle(0, 1, 8'h11);
    cycle(0, 1, 8'h22);
    cycle(0, 1, 8'h33);
    guard = 0;
    while (!(have_pop[0] && e == last_pop[0] + 2) && guard < 50) begin
      cycle(0, 0, 8'h00);
      guard++;
    end
    check("hold_reached", 32'(guard < 50), 32'(1));
    check("hold_enable_high", 32'(bus_a.bus_enable), 32'(1));
    for (int i = 0; i < 4; i++) cycle(1, 0, 8'h00);
    check("mid_hold_enable", 32'(bus_a.bus_enable), 32'(0));
    check("mid_hold_busy", 32'(bus_a.busy), 32'(0));
    check("mid_hold_bus", 32'(bus_a.unsync_bus), 32'(0));
    for (int i = 0; i < 20; i++) cycle(0, 0, 8'h00);

    // Random traffic with random gaps and occasional resets.
    rst_left = 0;
    for (int i = 0; i < 4000; i++) begin
      if (rst_left > 0) begin
        rst_left--;
        cycle(1, 1'($urandom_range(0, 1)), 8'($urandom));
      end else if ($urandom_range(0, 599) == 0) begin
        rst_left = 3;
        cycle(1, 1'($urandom_range(0, 1)), 8'($urandom));
      end else begin
        v = ($urandom_range(0, 99) < 55);
        cycle(0, v, 8'($urandom));
      end
    end

    for (int i = 0; i < 200; i++) cycle(0, 0, 8'h00);
    check("dest_all_delivered", 32'(dq.size()), 32'(0));
    check("dest_enough_words", 32'(words_seen >= 200), 32'(1));
    check("final_busy_a", 32'(bus_a.busy), 32'(0));
    check("final_busy_b", 32'(bus_b.busy), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
